reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, giving the number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter LOCK_FILTER, default 256, giving the consecutive pll_locked cycles required before sequencing.
REQ-003 SHALL have parameter HOLD_CYCLES, default 10000, giving the all-reset hold time (100 us at 100 MHz).
REQ-004 SHALL have parameter GAP_CYCLES, default 1000, giving the gap between a stage's ready and the next stage's release.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the per-stage ready timeout.
REQ-006 SHALL have port clk_in, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked, input, 1 bit: clock-source lock, synchronous to clk_in.
REQ-009 SHALL have port seq_req, input, 1 bit: single-cycle request to re-run the sequence.
REQ-010 SHALL have port stage_ready, input, NUM_STAGES bits: per-domain ready acknowledge.
REQ-011 SHALL have port stage_rst, output, NUM_STAGES bits: per-domain active-high reset, registered.
REQ-012 SHALL have port busy, output, 1 bit: sequencing in progress.
REQ-013 SHALL have port done, output, 1 bit: all domains released and ready.
REQ-014 SHALL have port fault, output, NUM_STAGES bits: sticky per-stage timeout flags.
REQ-015 SHALL have port state, output, 3 bits: current FSM state, for debug.

Function
REQ-016 SHALL implement states LOCK=0, HOLD=1, RELEASE=2, WAIT_RDY=3, GAP=4 and RUN=5, with one shared cycle counter and a stage index idx.
REQ-017 LOCK: SHALL count consecutive pll_locked=1 cycles, clear the count on pll_locked=0, and enter HOLD after LOCK_FILTER consecutive ones.
REQ-018 HOLD: SHALL keep every stage_rst bit at 1 for exactly HOLD_CYCLES cycles, then enter RELEASE with idx=0.
REQ-019 RELEASE: SHALL last one cycle, drive stage_rst[idx] to 0 from that cycle onward, and enter WAIT_RDY.
REQ-020 WAIT_RDY: on stage_ready[idx]=1 SHALL enter RUN if idx=NUM_STAGES-1, otherwise enter GAP.
REQ-021 GAP: SHALL wait exactly GAP_CYCLES cycles, increment idx, then enter RELEASE.
REQ-022 RUN: SHALL drive done=1 and busy=0; in every other state done=0 and busy=1.
REQ-023 Released stages (bits below idx, plus bit idx after RELEASE) SHALL stay at 0; unreleased stages SHALL stay at 1.
REQ-024 In any state other than LOCK, pll_locked=0 SHALL set every stage_rst bit to 1 and enter LOCK on the next edge.
REQ-025 seq_req=1 in RUN SHALL set every stage_rst bit to 1 and enter HOLD; seq_req in any other state SHALL be ignored.
REQ-026 When pll_locked=0 and seq_req=1 occur in the same cycle, the pll loss SHALL take priority.
REQ-027 Counters SHALL be wide enough for the largest parameter and SHALL never wrap; compare-equal terminates each count.

Reset
REQ-028 While rst_n=0, the block SHALL force: all stage_rst bits to 1, busy=1, done=0, fault=0, state=LOCK, idx=0, counter=0.
REQ-029 Deassertion of rst_n mid-sequence SHALL restart sequencing from LOCK; no partial progress is retained.

Configuration
REQ-030 With RSTSEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in WAIT_RDY SHALL set fault[idx] and proceed as if stage_ready[idx]=1.
REQ-031 fault bits SHALL be cleared only by rst_n.
REQ-032 Without RSTSEQ_TIMEOUT_EN, fault SHALL be tied to 0 and WAIT_RDY SHALL wait indefinitely.

Structure
REQ-033 Package rst_seq_pkg SHALL hold the state enumeration, its 3-bit width and the default parameter constants.
REQ-034 Lock qualification SHALL be the sub-module lock_filter (clk_in, rst_n, pll_locked -> locked_q).

Verification
All scenarios use NUM_STAGES=4, LOCK_FILTER=4, HOLD_CYCLES=8, GAP_CYCLES=2, TIMEOUT_CYCLES=16.
REQ-035 Nominal: pll_locked=1 and each stage_ready rising 3 cycles after its release -> releases in order 0,1,2,3; 4 cycles LOCK, 8 cycles HOLD, 2-cycle gaps; then done=1, busy=0.
REQ-036 Lock glitch: pll_locked drops during GAP after stage 1 -> stage_rst=4'b1111 next cycle, state=LOCK; resequencing completes normally.
REQ-037 Lock-filter boundary: pll_locked high 3 cycles, low 1 cycle, then high -> HOLD entered only after 4 further consecutive highs.
REQ-038 Re-run: seq_req pulse in RUN -> stage_rst=4'b1111, state=HOLD, done=0, then full release sequence; seq_req pulse during HOLD -> no effect.
REQ-039 Timeout (RSTSEQ_TIMEOUT_EN): stage_ready[2] held 0 -> after 16 cycles fault=4'b0100, stage 3 released, done=1; without the macro the FSM stays in WAIT_RDY and fault=0.
REQ-040 Async reset: rst_n pulsed low during WAIT_RDY of stage 3 -> all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer: state encoding, state width,
// default timing constants and a counter-width helper.
package rst_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_LOCK     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_GAP      = 3'd4,
        ST_RUN      = 3'd5
    } state_e;

    localparam int DEF_NUM_STAGES     = 4;
    localparam int DEF_LOCK_FILTER    = 256;
    localparam int DEF_HOLD_CYCLES    = 10000;
    localparam int DEF_GAP_CYCLES     = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    // Bits needed to hold 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Lock qualification: locked_q is high on the cycle that completes LOCK_FILTER
// consecutive pll_locked=1 cycles, and stays high while lock holds.
module lock_filter
    import rst_seq_pkg::*;
#(
    parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic pll_locked,
    output logic locked_q
);

    localparam int W = cnt_width(LOCK_FILTER);
    localparam logic [W-1:0] RUN_LAST = W'(LOCK_FILTER - 1);

    logic [W-1:0] run_r;

    // Consecutive-lock run length, saturating at the qualification point.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= {W{1'b0}};
        end else if (!pll_locked) begin
            run_r <= {W{1'b0}};
        end else if (run_r != RUN_LAST) begin
            run_r <= run_r + W'(1);
        end else begin
            run_r <= run_r;
        end
    end

    assign locked_q = pll_locked && (run_r == RUN_LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: qualify PLL lock, hold all domains in reset, then release
// them one by one, waiting for each ready plus a gap. Define RSTSEQ_TIMEOUT_EN to
// enable per-stage ready timeouts with sticky fault flags.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  seq_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_STAGES-1:0] fault,
    output logic [STATE_W-1:0]    state
);

    localparam int CNT_W = cnt_width(max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES));
    localparam int IDX_W = cnt_width(NUM_STAGES);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);

    state_e                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [NUM_STAGES-1:0]   stage_rst_r, stage_rst_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    locked_s;
    logic                    timeout_s;

    lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .locked_q   (locked_s)
    );

    // Timeout strobe: a waiting stage has used up its budget without answering.
    always_comb begin
`ifdef RSTSEQ_TIMEOUT_EN
        timeout_s = (state_r == ST_WAIT_RDY) && pll_locked &&
                    !stage_ready[idx_r] && (cnt_r == TIMEOUT_LAST);
`else
        timeout_s = 1'b0;
`endif
    end

    // State, stage index, shared counter and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOCK;
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            stage_rst_r <= {NUM_STAGES{1'b1}};
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            stage_rst_r <= stage_rst_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Next-state logic; lock loss overrides everything, including a re-run request.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        if ((state_r != ST_LOCK) && !pll_locked) begin
            state_s = ST_LOCK;
            idx_s   = {IDX_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_LOCK: begin
                    if (locked_s) begin
                        state_s = ST_HOLD;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_LOCK;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_s = ST_RELEASE;
                        idx_s   = {IDX_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state_s = ST_WAIT_RDY;
                    cnt_s   = {CNT_W{1'b0}};
                end
                ST_WAIT_RDY: begin
                    if (stage_ready[idx_r] || timeout_s) begin
                        cnt_s = {CNT_W{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            state_s = ST_RUN;
                        end else begin
                            state_s = ST_GAP;
                        end
                    end else if (cnt_r != TIMEOUT_LAST) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_s = ST_RELEASE;
                        idx_s   = idx_r + IDX_W'(1);
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (seq_req) begin
                        state_s = ST_HOLD;
                        idx_s   = {IDX_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_LOCK;
                    idx_s   = {IDX_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Outputs derived from the upcoming state so the registered copies line up with it.
    always_comb begin
        stage_rst_s = {NUM_STAGES{1'b1}};
        busy_s      = 1'b1;
        done_s      = 1'b0;
        case (state_s)
            ST_RELEASE, ST_WAIT_RDY, ST_GAP: begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    stage_rst_s[i] = (i > int'(idx_s)) ? 1'b1 : 1'b0;
                end
            end
            ST_RUN: begin
                stage_rst_s = {NUM_STAGES{1'b0}};
                busy_s      = 1'b0;
                done_s      = 1'b1;
            end
            default: begin
                stage_rst_s = {NUM_STAGES{1'b1}};
            end
        endcase
    end

`ifdef RSTSEQ_TIMEOUT_EN
    logic [NUM_STAGES-1:0] fault_r;

    // Sticky timeout flags; only the hard reset clears them.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= {NUM_STAGES{1'b0}};
        end else if (timeout_s) begin
            fault_r[idx_r] <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`else
    assign fault = {NUM_STAGES{1'b0}};
`endif

    assign stage_rst = stage_rst_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign state     = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_reset_sequencer;

    localparam int NS = 4;
    localparam int LF = 4;
    localparam int HOLD = 8;
    localparam int GAP = 2;
    localparam int TO = 16;
    localparam int S_LOCK = 0, S_HOLD = 1, S_REL = 2, S_WAIT = 3, S_GAP = 4, S_RUN = 5;
`ifdef RSTSEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b1;
    logic          seq_req = 1'b0;
    logic [NS-1:0] stage_ready = '0;
    logic [NS-1:0] stage_rst;
    logic          busy;
    logic          done;
    logic [NS-1:0] fault;
    logic [2:0]    state;

    logic [NS-1:0] stuck = '0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;

    // reference model: a stage is described only by when it was released and answered
    bit            seq_on;
    int            lock_run;
    int            rel_at[NS];
    int            rdy_at[NS];
    logic [NS-1:0] m_fault;

    // statistics for the directed checks
    int            state_cycles[8];
    int            fall_at[NS];
    int            done_at;

    reset_sequencer #(
        .NUM_STAGES     (NS),
        .LOCK_FILTER    (LF),
        .HOLD_CYCLES    (HOLD),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .seq_req     (seq_req),
        .stage_ready (stage_ready),
        .stage_rst   (stage_rst),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .state       (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic void clear_seq();
        seq_on = 1'b0;
        for (int k = 0; k < NS; k++) begin
            rel_at[k] = -1;
            rdy_at[k] = -1;
        end
    endfunction

    function automatic void model_reset();
        clear_seq();
        lock_run = 0;
        m_fault = '0;
    endfunction

    function automatic void start_seq(input int c);
        clear_seq();
        seq_on = 1'b1;
        rel_at[0] = c + 1 + HOLD;
    endfunction

    function automatic int m_stage(input int c);
        int k = -1;
        for (int j = 0; j < NS; j++) begin
            if (rel_at[j] >= 0 && rel_at[j] <= c) k = j;
        end
        return k;
    endfunction

    function automatic int m_state(input int c);
        int k;
        if (!seq_on) return S_LOCK;
        k = m_stage(c);
        if (k < 0) return S_HOLD;
        if (c == rel_at[k]) return S_REL;
        if (rdy_at[k] < 0) return S_WAIT;
        if (k == NS - 1) return S_RUN;
        return S_GAP;
    endfunction

    function automatic int m_rst(input int c);
        int r = 0;
        for (int j = 0; j < NS; j++) begin
            if (!(rel_at[j] >= 0 && rel_at[j] <= c)) r |= (1 << j);
        end
        return r;
    endfunction

    function automatic void accept(input int c, input int k);
        rdy_at[k] = c;
        if (k < NS - 1) rel_at[k+1] = c + 1 + GAP;
    endfunction

    // Advance the model across the clock edge that ends cycle c, using current inputs.
    function automatic void model_edge(input int c);
        int st = m_state(c);
        int k = m_stage(c);
        if (st != S_LOCK && !pll_locked) begin
            clear_seq();
            lock_run = 0;
        end else if (st == S_LOCK) begin
            lock_run = pll_locked ? lock_run + 1 : 0;
            if (lock_run == LF) start_seq(c);
        end else if (st == S_WAIT) begin
            if (stage_ready[k]) begin
                accept(c, k);
            end else if (TO_EN && (c - rel_at[k]) == TO) begin
                m_fault[k] = 1'b1;
                accept(c, k);
            end
        end else if (st == S_RUN && seq_req) begin
            start_seq(c);
        end
    endfunction

    function automatic void clear_stats();
        for (int s = 0; s < 8; s++) state_cycles[s] = 0;
        for (int k = 0; k < NS; k++) fall_at[k] = -1;
        done_at = -1;
    endfunction

    // Per-cycle compare against the model, then advance it.
    initial begin
        int es;
        model_reset();
        clear_stats();
        forever begin
            @(negedge clk_in);
            if (!rst_n) model_reset();
            es = m_state(cyc);
            check("state", int'(state), es);
            check("stage_rst", int'(stage_rst), m_rst(cyc));
            check("busy", int'(busy), (es != S_RUN) ? 1 : 0);
            check("done", int'(done), (es == S_RUN) ? 1 : 0);
            check("fault", int'(fault), int'(m_fault));
            state_cycles[state]++;
            for (int k = 0; k < NS; k++) begin
                if (!stage_rst[k] && fall_at[k] < 0) fall_at[k] = cyc;
            end
            if (done && done_at < 0) done_at = cyc;
            if (rst_n) model_edge(cyc);
            cyc++;
        end
    end

    // Domain responder: ready three cycles into release unless the stage is stuck.
    initial begin
        int age[NS];
        for (int k = 0; k < NS; k++) age[k] = 0;
        forever begin
            @(posedge clk_in);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (stage_rst[k]) begin
                    age[k] = 0;
                    stage_ready[k] = 1'b0;
                end else begin
                    age[k]++;
                    stage_ready[k] = (age[k] >= 3) && !stuck[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_for(input string name, input int want, input int pat,
                            input bit use_pat, input int budget);
        int n = 0;
        while (!(int'(state) == want && (!use_pat || int'(stage_rst) == pat)) && n < budget) begin
            tick();
            n++;
        end
        check(name, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " stage_rst"}, int'(stage_rst), 15);
        check({tag, " busy"}, int'(busy), 1);
        check({tag, " done"}, int'(done), 0);
        check({tag, " fault"}, int'(fault), 0);
        check({tag, " state"}, int'(state), S_LOCK);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        seq_req = 1'b0;
        pll_locked = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic check_spacing(input string tag);
        check({tag, " rel1-rel0"}, fall_at[1] - fall_at[0], 5);
        check({tag, " rel2-rel1"}, fall_at[2] - fall_at[1], 5);
        check({tag, " rel3-rel2"}, fall_at[3] - fall_at[2], 5);
        check({tag, " done-rel3"}, done_at - fall_at[3], 3);
    endtask

    initial begin
        // nominal sequence
        apply_reset();
        wait_for("nominal run", S_RUN, 0, 1'b0, 200);
        tick();
        check("nominal lock cycles", state_cycles[S_LOCK], 4);
        check("nominal hold cycles", state_cycles[S_HOLD], 8);
        check_spacing("nominal");
        check("nominal done", int'(done), 1);
        check("nominal busy", int'(busy), 0);
        check("nominal stage_rst", int'(stage_rst), 0);

        // re-run request; a second request during HOLD is ignored
        seq_req = 1'b1;
        tick();
        seq_req = 1'b0;
        clear_stats();
        check("rerun state", int'(state), S_HOLD);
        check("rerun stage_rst", int'(stage_rst), 15);
        check("rerun done", int'(done), 0);
        repeat (3) tick();
        seq_req = 1'b1;
        tick();
        seq_req = 1'b0;
        wait_for("rerun run", S_RUN, 0, 1'b0, 200);
        tick();
        check("rerun hold cycles", state_cycles[S_HOLD], 8);
        check("rerun lock cycles", state_cycles[S_LOCK], 0);
        check_spacing("rerun");

        // lock loss during the gap after stage 1
        seq_req = 1'b1;
        tick();
        seq_req = 1'b0;
        wait_for("glitch gap", S_GAP, 12, 1'b1, 200);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        clear_stats();
        check("glitch stage_rst", int'(stage_rst), 15);
        check("glitch state", int'(state), S_LOCK);
        wait_for("glitch run", S_RUN, 0, 1'b0, 200);
        tick();
        check("glitch lock cycles", state_cycles[S_LOCK], 4);
        check("glitch done", int'(done), 1);

        // lock filter boundary: 3 highs, 1 low, then 4 more highs needed
        apply_reset();
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (3) tick();
        check("filter still lock", int'(state), S_LOCK);
        tick();
        check("filter hold", int'(state), S_HOLD);
        check("filter lock cycles", state_cycles[S_LOCK], 8);

        // async reset during WAIT_RDY of the last stage
        wait_for("async wait3", S_WAIT, 0, 1'b1, 200);
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        repeat (2) tick();
        rst_n = 1'b1;
        clear_stats();
        wait_for("async rerun", S_RUN, 0, 1'b0, 200);
        tick();
        check("async lock cycles", state_cycles[S_LOCK], 4);

        // stage 2 never answers
        stuck = 4'b0100;
        apply_reset();
`ifdef RSTSEQ_TIMEOUT_EN
        wait_for("timeout run", S_RUN, 0, 1'b0, 300);
        tick();
        check("timeout fault", int'(fault), 4);
        check("timeout done", int'(done), 1);
        check("timeout rel3-rel2", fall_at[3] - fall_at[2], 19);
`else
        repeat (80) tick();
        check("no-timeout state", int'(state), S_WAIT);
        check("no-timeout fault", int'(fault), 0);
        check("no-timeout stage_rst", int'(stage_rst), 8);
        check("no-timeout done", int'(done), 0);
`endif
        stuck = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
